// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer plus counter-qualified FSM producing a debounced button level
// Optional build macro: DEBOUNCE_ACTIVE_LOW_EN (raw button is active-low when defined).
module button_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic lp,
    output logic bouncing
);

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    localparam logic RAW_IDLE = 1'b1;
`else
    localparam logic RAW_IDLE = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   lp_n, bouncing_n;

    // The chain carries the raw level; polarity is normalised only at its output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RAW_IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ RAW_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE_LOW;
            cnt      <= '0;
            lp       <= 1'b0;
            bouncing <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lp       <= lp_n;
            bouncing <= bouncing_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_n = WAIT_HIGH;
                    cnt_n   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_n = IDLE_LOW;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE_HIGH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_n = WAIT_LOW;
                    cnt_n   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_n = IDLE_HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE_LOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE_LOW;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they never glitch.
    always_comb begin
        lp_n       = 1'b0;
        bouncing_n = 1'b0;
        case (state_n)
            WAIT_HIGH: bouncing_n = 1'b1;
            IDLE_HIGH: lp_n = 1'b1;
            WAIT_LOW: begin
                lp_n       = 1'b1;
                bouncing_n = 1'b1;
            end
            default: begin
                lp_n       = 1'b0;
                bouncing_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized bench against a run-length reference model
module tb_button_debouncer;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = ACT_LOW;
    logic lp, bouncing;

    logic press = 1'b0;

    int tests = 0;
    int fails = 0;

    button_debouncer #(
        .STABLE_CYCLES(STABLE),
        .CNT_W(16),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .lp(lp),
        .bouncing(bouncing)
    );

    always #5 clk = ~clk;

    // Reference: lp flips once the delayed press level has disagreed with it
    // for STABLE+1 consecutive samples; any agreeing sample clears the run.
    logic [SYNC-1:0] m_hist;
    int              m_run;
    logic            m_lp, m_bnc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist <= '0;
            m_run  <= 0;
            m_lp   <= 1'b0;
            m_bnc  <= 1'b0;
        end else begin
            automatic logic s_old = m_hist[SYNC-1];
            automatic int   r     = (s_old != m_lp) ? m_run + 1 : 0;
            automatic logic l     = m_lp;
            if (r == STABLE + 1) begin
                l = s_old;
                r = 0;
            end
            m_hist <= {m_hist[SYNC-2:0], press};
            m_run  <= r;
            m_lp   <= l;
            m_bnc  <= (r != 0);
        end
    end

    int lp_rises = 0;
    always @(posedge lp) if (!rst) lp_rises <= lp_rises + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic p);
        @(negedge clk);
        check("lp", 32'(lp), 32'(m_lp));
        check("bouncing", 32'(bouncing), 32'(m_bnc));
        press  = p;
        btn_in = p ^ ACT_LOW;
    endtask

    task automatic hold(input logic p, input int n);
        for (int i = 0; i < n; i++) cycle(p);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_lp", 32'(lp), 32'd0);
        check("reset_bouncing", 32'(bouncing), 32'd0);
        rst = 1'b0;
        hold(1'b0, 4);

        // clean press and release, then short glitches that must be rejected
        hold(1'b1, 10);
        check("press_lp", 32'(lp), 32'd1);
        hold(1'b0, 2);
        hold(1'b1, 8);
        check("glitch_lp", 32'(lp), 32'd1);
        hold(1'b0, 10);
        check("release_lp", 32'(lp), 32'd0);
        hold(1'b1, 3);
        hold(1'b0, 8);
        check("bounce_lp", 32'(lp), 32'd0);

        // random bounce trains with run lengths straddling the threshold
        for (int i = 0; i < 300; i++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, STABLE + 4));
        end

        // reset in the middle of a qualification
        hold(1'b0, 10);
        hold(1'b1, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_lp", 32'(lp), 32'd0);
        check("midrst_bouncing", 32'(bouncing), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1, SYNC + STABLE - 1);
        check("requal_early_lp", 32'(lp), 32'd0);
        hold(1'b1, 3);
        check("requal_lp", 32'(lp), 32'd1);

        // long hold: exactly one rising edge of lp, no bouncing afterwards
        hold(1'b0, 12);
        lp_rises = 0;
        hold(1'b1, 1000);
        check("long_rises", 32'(lp_rises), 32'd1);
        check("long_lp", 32'(lp), 32'd1);
        check("long_bouncing", 32'(bouncing), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
